// File: rtl/cachemem_assoc.sv
// N-way set-associative cache storage array with true-LRU replacement.
// Combinational lookup ports, one write/allocate port, one invalidate port,
// and a registered report of the line displaced by the previous write.
module cachemem_assoc #(
  parameter  int NUM_SETS     = 16,
  parameter  int NUM_WAYS     = 2,
  parameter  int TAG_BITS     = 8,
  parameter  int DATA_BITS    = 64,
  parameter  int NUM_RD_PORTS = 2,
  localparam int IDX_BITS     = $clog2(NUM_SETS),
  localparam int WAY_BITS     = $clog2(NUM_WAYS)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_RD_PORTS*IDX_BITS-1:0]     rd_idx,
  input  logic [NUM_RD_PORTS*TAG_BITS-1:0]     rd_tag,
  input  logic [NUM_RD_PORTS-1:0]              rd_en,
  output logic [NUM_RD_PORTS*DATA_BITS-1:0]    rd_data,
  output logic [NUM_RD_PORTS-1:0]              rd_valid,
  input  logic                                 wr_en,
  input  logic [IDX_BITS-1:0]                  wr_idx,
  input  logic [TAG_BITS-1:0]                  wr_tag,
  input  logic [DATA_BITS-1:0]                 wr_data,
  input  logic                                 inv_en,
  input  logic [IDX_BITS-1:0]                  inv_idx,
  input  logic [TAG_BITS-1:0]                  inv_tag,
  output logic                                 evict_valid,
  output logic [IDX_BITS-1:0]                  evict_idx,
  output logic [TAG_BITS-1:0]                  evict_tag,
  output logic [DATA_BITS-1:0]                 evict_data,
  output logic [NUM_SETS*NUM_WAYS-1:0]         valids_out,
  output logic [NUM_SETS*NUM_WAYS*TAG_BITS-1:0] tags_out
);

  localparam logic [WAY_BITS-1:0] AGE_LRU = WAY_BITS'(NUM_WAYS - 1);

  // Storage state
  logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]  valid_d [NUM_SETS];
  logic [TAG_BITS-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_BITS-1:0]  tag_d   [NUM_SETS][NUM_WAYS];
  logic [DATA_BITS-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic [DATA_BITS-1:0] data_d  [NUM_SETS][NUM_WAYS];
  logic [WAY_BITS-1:0]  age_q   [NUM_SETS][NUM_WAYS];
  logic [WAY_BITS-1:0]  age_d   [NUM_SETS][NUM_WAYS];
  logic [WAY_BITS-1:0]  age_init [NUM_SETS][NUM_WAYS];

  // Eviction report registers
  logic                 evict_valid_q, evict_valid_d;
  logic [IDX_BITS-1:0]  evict_idx_q,   evict_idx_d;
  logic [TAG_BITS-1:0]  evict_tag_q,   evict_tag_d;
  logic [DATA_BITS-1:0] evict_data_q,  evict_data_d;

  // Lookup results
  logic [IDX_BITS-1:0]  rd_idx_a [NUM_RD_PORTS];
  logic [TAG_BITS-1:0]  rd_tag_a [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0] rd_hit;
  logic [WAY_BITS-1:0]  rd_way [NUM_RD_PORTS];

  // Write / invalidate decode
  logic                 wr_hit;
  logic [WAY_BITS-1:0]  wr_hit_way;
  logic                 have_invalid;
  logic [WAY_BITS-1:0]  invalid_way;
  logic [WAY_BITS-1:0]  lru_way;
  logic [WAY_BITS-1:0]  wr_way;
  logic                 inv_hit;
  logic [WAY_BITS-1:0]  inv_way;

  // Per-set touch selection
  logic [NUM_SETS-1:0]  touch_en;
  logic [WAY_BITS-1:0]  touch_way [NUM_SETS];

  // Reset value of the age array: way w starts with age w
  always_comb begin
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < NUM_WAYS; w++)
        age_init[s][w] = WAY_BITS'(w);
  end

  // Combinational lookup on pre-edge contents; data is zero on a miss
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
    rd_data = '0;
    rd_hit  = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_idx_a[p] = rd_idx[p*IDX_BITS +: IDX_BITS];
      rd_tag_a[p] = rd_tag[p*TAG_BITS +: TAG_BITS];
      rd_way[p]   = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (valid_q[rd_idx_a[p]][w] && (tag_q[rd_idx_a[p]][w] == rd_tag_a[p])) begin
          rd_hit[p] = 1'b1;
          rd_way[p] = WAY_BITS'(w);
          rd_data[p*DATA_BITS +: DATA_BITS] = data_q[rd_idx_a[p]][w];
        end
      end
    end
  end

  assign rd_valid = rd_hit;

  // Write hit detection and victim choice, all from pre-edge valids and ages
  always_comb begin
    wr_hit       = 1'b0;
    wr_hit_way   = '0;
    have_invalid = 1'b0;
    invalid_way  = '0;
    lru_way      = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[wr_idx][w] && (tag_q[wr_idx][w] == wr_tag)) begin
        wr_hit     = 1'b1;
        wr_hit_way = WAY_BITS'(w);
      end
      if (!have_invalid && !valid_q[wr_idx][w]) begin
        have_invalid = 1'b1;
        invalid_way  = WAY_BITS'(w);
      end
      if (age_q[wr_idx][w] == AGE_LRU)
        lru_way = WAY_BITS'(w);
    end
    if (wr_hit)            wr_way = wr_hit_way;
    else if (have_invalid) wr_way = invalid_way;
    else                   wr_way = lru_way;
  end

  // Invalidate match on pre-edge state
  always_comb begin
    inv_hit = 1'b0;
    inv_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[inv_idx][w] && (tag_q[inv_idx][w] == inv_tag)) begin
        inv_hit = 1'b1;
        inv_way = WAY_BITS'(w);
      end
    end
  end

  // One LRU touch per set: the write claims its set first, then read ports in order
  always_comb begin
    touch_en = '0;
    for (int s = 0; s < NUM_SETS; s++) touch_way[s] = '0;
    if (wr_en) begin
      touch_en[wr_idx]  = 1'b1;
      touch_way[wr_idx] = wr_way;
    end
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (rd_en[p] && rd_hit[p] && !touch_en[rd_idx_a[p]]) begin
        touch_en[rd_idx_a[p]]  = 1'b1;
        touch_way[rd_idx_a[p]] = rd_way[p];
      end
    end
  end

  // Next-state for arrays and eviction report; the write is applied after the invalidate so it wins
  always_comb begin
    valid_d       = valid_q;
    tag_d         = tag_q;
    data_d        = data_q;
    age_d         = age_q;
    evict_valid_d = 1'b0;
    evict_idx_d   = evict_idx_q;
    evict_tag_d   = evict_tag_q;
    evict_data_d  = evict_data_q;

    if (inv_en && inv_hit)
      valid_d[inv_idx][inv_way] = 1'b0;

    if (wr_en) begin
      if (!wr_hit && valid_q[wr_idx][wr_way]) begin
        evict_valid_d = 1'b1;
        evict_idx_d   = wr_idx;
        evict_tag_d   = tag_q[wr_idx][wr_way];
        evict_data_d  = data_q[wr_idx][wr_way];
      end
      tag_d[wr_idx][wr_way]   = wr_tag;
      data_d[wr_idx][wr_way]  = wr_data;
      valid_d[wr_idx][wr_way] = 1'b1;
    end

    for (int s = 0; s < NUM_SETS; s++) begin
      if (touch_en[s]) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (touch_way[s] == WAY_BITS'(w))
            age_d[s][w] = '0;
          else if (age_q[s][w] < age_q[s][touch_way[s]])
            age_d[s][w] = age_q[s][w] + 1'b1;
        end
      end
    end
  end

  // Control state: valids, ages and eviction report, cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q       <= '{default: '0};
      age_q         <= age_init;
      evict_valid_q <= 1'b0;
      evict_idx_q   <= '0;
      evict_tag_q   <= '0;
      evict_data_q  <= '0;
    end else begin
      valid_q       <= valid_d;
      age_q         <= age_d;
      evict_valid_q <= evict_valid_d;
      evict_idx_q   <= evict_idx_d;
      evict_tag_q   <= evict_tag_d;
      evict_data_q  <= evict_data_d;
    end
  end

  // Tag and data arrays: held (not written) during reset
  always_ff @(posedge clock) begin
    // NOTE: tag/data are storage arrays and are deliberately not cleared; the valid bits alone make them invisible after reset.
    if (!reset) begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign evict_valid = evict_valid_q;
  assign evict_idx   = evict_idx_q;
  assign evict_tag   = evict_tag_q;
  assign evict_data  = evict_data_q;

  // Flattened debug view of valids and tags, ordered set*NUM_WAYS+way
  always_comb begin
    valids_out = '0;
    tags_out   = '0;
    for (int s = 0; s < NUM_SETS; s++) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        valids_out[s*NUM_WAYS + w]                  = valid_q[s][w];
        tags_out[(s*NUM_WAYS + w)*TAG_BITS +: TAG_BITS] = tag_q[s][w];
      end
    end
  end

endmodule

// File: tb/tb_cachemem_assoc.sv
// Self-checking bench for cachemem_assoc (16 sets, 2 ways, 8-bit tags, 64-bit data, 2 read ports).
module tb_cachemem_assoc;

  localparam int NS = 16;
  localparam int NW = 2;
  localparam int TB = 8;
  localparam int DB = 64;
  localparam int NP = 2;
  localparam int IB = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NP*IB-1:0]     rd_idx;
  logic [NP*TB-1:0]     rd_tag;
  logic [NP-1:0]        rd_en;
  logic [NP*DB-1:0]     rd_data;
  logic [NP-1:0]        rd_valid;
  logic                 wr_en;
  logic [IB-1:0]        wr_idx;
  logic [TB-1:0]        wr_tag;
  logic [DB-1:0]        wr_data;
  logic                 inv_en;
  logic [IB-1:0]        inv_idx;
  logic [TB-1:0]        inv_tag;
  logic                 evict_valid;
  logic [IB-1:0]        evict_idx;
  logic [TB-1:0]        evict_tag;
  logic [DB-1:0]        evict_data;
  logic [NS*NW-1:0]     valids_out;
  logic [NS*NW*TB-1:0]  tags_out;

  cachemem_assoc #(
    .NUM_SETS(NS), .NUM_WAYS(NW), .TAG_BITS(TB), .DATA_BITS(DB), .NUM_RD_PORTS(NP)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_idx(rd_idx), .rd_tag(rd_tag), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag(wr_tag), .wr_data(wr_data),
    .inv_en(inv_en), .inv_idx(inv_idx), .inv_tag(inv_tag),
    .evict_valid(evict_valid), .evict_idx(evict_idx),
    .evict_tag(evict_tag), .evict_data(evict_data),
    .valids_out(valids_out), .tags_out(tags_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          rst;
    bit          wr;  logic [3:0] wi; logic [7:0] wt; logic [63:0] wd;
    bit          inv; logic [3:0] ii; logic [7:0] it;
    logic [1:0]  re;
    logic [3:0]  ri0; logic [7:0] rt0;
    logic [3:0]  ri1; logic [7:0] rt1;
    bit          chk;
    logic [1:0]  xv; logic [63:0] xd0; logic [63:0] xd1;
    logic [31:0] xvalids;
    logic        xev; logic [3:0] xei; logic [7:0] xet; logic [63:0] xed;
  } vec_t;

  typedef struct {
    int          id;
    logic [1:0]  xv; logic [63:0] xd0; logic [63:0] xd1;
    logic [31:0] xvalids;
    logic        xev; logic [3:0] xei; logic [7:0] xet; logic [63:0] xed;
  } exp_t;

  vec_t vecs[$];
  vec_t cur;
  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  localparam logic [63:0] D33B = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] DX   = 64'h5555_AAAA_0000_0001;

  function automatic logic [63:0] dat(input logic [7:0] t);
    return {48'hC0DE_5EED_0000, t, ~t};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic vin(input bit rst, input bit wr, input logic [3:0] wi, input logic [7:0] wt,
                     input logic [63:0] wd, input bit inv, input logic [3:0] ii, input logic [7:0] it,
                     input logic [1:0] re, input logic [3:0] ri0, input logic [7:0] rt0,
                     input logic [3:0] ri1, input logic [7:0] rt1);
    cur = '{default: '0};
    cur.rst = rst; cur.wr = wr; cur.wi = wi; cur.wt = wt; cur.wd = wd;
    cur.inv = inv; cur.ii = ii; cur.it = it; cur.re = re;
    cur.ri0 = ri0; cur.rt0 = rt0; cur.ri1 = ri1; cur.rt1 = rt1;
  endtask

  task automatic vexp(input logic [1:0] xv, input logic [63:0] xd0, input logic [63:0] xd1,
                      input logic [31:0] xvalids, input logic xev, input logic [3:0] xei,
                      input logic [7:0] xet, input logic [63:0] xed);
    cur.chk = 1'b1; cur.xv = xv; cur.xd0 = xd0; cur.xd1 = xd1; cur.xvalids = xvalids;
    cur.xev = xev; cur.xei = xei; cur.xet = xet; cur.xed = xed;
    vecs.push_back(cur);
  endtask

  task automatic vskip();
    cur.chk = 1'b0;
    vecs.push_back(cur);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_tag = '0; wr_data = '0;
    inv_en = 1'b0; inv_idx = '0; inv_tag = '0; rd_en = '0; rd_idx = '0; rd_tag = '0;
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst;
    wr_en = v.wr; wr_idx = v.wi; wr_tag = v.wt; wr_data = v.wd;
    inv_en = v.inv; inv_idx = v.ii; inv_tag = v.it;
    rd_en = v.re; rd_idx = {v.ri1, v.ri0}; rd_tag = {v.rt1, v.rt0};
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;

    // Vector table: inputs held for one cycle; expectations are the pre-edge view in that cycle.
    // Set 3 ways: bit6 = way0, bit7 = way1; set 5 way0 = bit10.
    vin(1,1,3,8'h99,dat(8'h99),0,0,0,2'b00,3,8'h99,0,8'h00); vskip();
    vin(0,0,0,0,0,0,0,0,2'b00,3,8'h99,0,8'h00);
    vexp(2'b00,0,0,32'h0,0,0,0,0);
    vin(0,1,3,8'h11,dat(8'h11),0,0,0,2'b01,3,8'h11,0,8'h00);
    vexp(2'b00,0,0,32'h0,0,0,0,0);
    vin(0,1,3,8'h22,dat(8'h22),0,0,0,2'b00,3,8'h11,3,8'h22);
    vexp(2'b01,dat(8'h11),0,32'h40,0,0,0,0);
    vin(0,0,0,0,0,0,0,0,2'b01,3,8'h11,3,8'h22);
    vexp(2'b11,dat(8'h11),dat(8'h22),32'hC0,0,0,0,0);
    vin(0,1,3,8'h33,dat(8'h33),0,0,0,2'b00,3,8'h11,3,8'h22);
    vexp(2'b11,dat(8'h11),dat(8'h22),32'hC0,0,0,0,0);
    vin(0,0,0,0,0,0,0,0,2'b00,3,8'h33,3,8'h22);
    vexp(2'b01,dat(8'h33),0,32'hC0,1,3,8'h22,dat(8'h22));
    vin(0,1,3,8'h33,D33B,0,0,0,2'b01,3,8'h11,3,8'h33);
    vexp(2'b11,dat(8'h11),dat(8'h33),32'hC0,0,3,8'h22,dat(8'h22));
    vin(0,1,3,8'h44,dat(8'h44),0,0,0,2'b00,3,8'h33,3,8'h11);
    vexp(2'b11,D33B,dat(8'h11),32'hC0,0,3,8'h22,dat(8'h22));
    vin(0,0,0,0,0,1,3,8'h33,2'b00,3,8'h44,3,8'h11);
    vexp(2'b01,dat(8'h44),0,32'hC0,1,3,8'h11,dat(8'h11));
    vin(0,1,3,8'h55,dat(8'h55),0,0,0,2'b00,3,8'h33,3,8'h44);
    vexp(2'b10,0,dat(8'h44),32'h40,0,3,8'h11,dat(8'h11));
    vin(0,0,0,0,0,0,0,0,2'b00,3,8'h55,3,8'h44);
    vexp(2'b11,dat(8'h55),dat(8'h44),32'hC0,0,3,8'h11,dat(8'h11));
    vin(0,1,5,8'h07,dat(8'h07),0,0,0,2'b01,5,8'h07,3,8'h55);
    vexp(2'b10,0,dat(8'h55),32'hC0,0,3,8'h11,dat(8'h11));
    vin(0,0,0,0,0,0,0,0,2'b00,5,8'h07,5,8'h08);
    vexp(2'b01,dat(8'h07),0,32'h4C0,0,3,8'h11,dat(8'h11));
    vin(0,1,3,8'h55,DX,1,3,8'h55,2'b00,3,8'h55,3,8'h44);
    vexp(2'b11,dat(8'h55),dat(8'h44),32'h4C0,0,3,8'h11,dat(8'h11));
    vin(0,0,0,0,0,1,5,8'h99,2'b00,3,8'h55,5,8'h07);
    vexp(2'b11,DX,dat(8'h07),32'h4C0,0,3,8'h11,dat(8'h11));
    vin(0,0,0,0,0,0,0,0,2'b00,5,8'h07,3,8'h44);
    vexp(2'b11,dat(8'h07),dat(8'h44),32'h4C0,0,3,8'h11,dat(8'h11));

    for (int i = 0; i < vecs.size(); i++) begin
      step();
      drive(vecs[i]);
      if (vecs[i].chk)
        sb.push_back('{id: i, xv: vecs[i].xv, xd0: vecs[i].xd0, xd1: vecs[i].xd1,
                       xvalids: vecs[i].xvalids, xev: vecs[i].xev, xei: vecs[i].xei,
                       xet: vecs[i].xet, xed: vecs[i].xed});
      @(negedge clock);
      if (vecs[i].chk) begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("v%0d rd_valid", e.id), 64'(rd_valid), 64'(e.xv));
        check($sformatf("v%0d rd_data0", e.id), rd_data[0 +: DB], e.xd0);
        check($sformatf("v%0d rd_data1", e.id), rd_data[DB +: DB], e.xd1);
        check($sformatf("v%0d valids_out", e.id), 64'(valids_out), 64'(e.xvalids));
        check($sformatf("v%0d evict_valid", e.id), 64'(evict_valid), 64'(e.xev));
        check($sformatf("v%0d evict_idx", e.id), 64'(evict_idx), 64'(e.xei));
        check($sformatf("v%0d evict_tag", e.id), 64'(evict_tag), 64'(e.xet));
        check($sformatf("v%0d evict_data", e.id), evict_data, e.xed);
      end
    end
    check("scoreboard drained", 64'(sb.size()), 64'd0);

    // Mid-run reset with a competing write and invalidate: reset wins, tags retained.
    step();
    idle_inputs();
    reset = 1'b1;
    wr_en = 1'b1; wr_idx = 4'd3; wr_tag = 8'h77; wr_data = dat(8'h77);
    inv_en = 1'b1; inv_idx = 4'd3; inv_tag = 8'h44;
    step();
    idle_inputs();
    rd_idx = {4'd3, 4'd3}; rd_tag = {8'h55, 8'h44};
    @(negedge clock);
    check("rst valids_out", 64'(valids_out), 64'd0);
    check("rst rd_valid", 64'(rd_valid), 64'd0);
    check("rst rd_data", rd_data[0 +: DB] | rd_data[DB +: DB], 64'd0);
    check("rst evict_valid", 64'(evict_valid), 64'd0);
    check("rst evict_idx", 64'(evict_idx), 64'd0);
    check("rst evict_tag", 64'(evict_tag), 64'd0);
    check("rst evict_data", evict_data, 64'd0);
    check("rst tag set3 way0 kept", 64'(tags_out[(3*NW+0)*TB +: TB]), 64'h44);
    check("rst tag set3 way1 kept", 64'(tags_out[(3*NW+1)*TB +: TB]), 64'h55);

    // Refill after reset: reset ages give way0, way1, then the oldest (way0) is evicted.
    step();
    wr_en = 1'b1; wr_idx = 4'd3; wr_tag = 8'hA1; wr_data = dat(8'hA1);
    rd_idx = {4'd0, 4'd3}; rd_tag = {8'h00, 8'hA1};
    @(negedge clock);
    check("refill rd not forwarded", 64'(rd_valid), 64'd0);
    step();
    wr_tag = 8'hA2; wr_data = dat(8'hA2);
    @(negedge clock);
    check("refill1 evict_valid", 64'(evict_valid), 64'd0);
    check("refill1 valids", 64'(valids_out), 64'h40);
    step();
    wr_tag = 8'hA3; wr_data = dat(8'hA3);
    @(negedge clock);
    check("refill2 evict_valid", 64'(evict_valid), 64'd0);
    check("refill2 valids", 64'(valids_out), 64'hC0);
    step();
    idle_inputs();
    rd_idx = {4'd3, 4'd3}; rd_tag = {8'hA1, 8'hA3};
    @(negedge clock);
    check("refill3 evict_valid", 64'(evict_valid), 64'd1);
    check("refill3 evict_idx", 64'(evict_idx), 64'd3);
    check("refill3 evict_tag", 64'(evict_tag), 64'hA1);
    check("refill3 evict_data", evict_data, dat(8'hA1));
    check("refill3 rd_valid", 64'(rd_valid), 64'b01);
    check("refill3 rd_data0", rd_data[0 +: DB], dat(8'hA3));
    step();
    @(negedge clock);
    check("refill4 evict pulse ends", 64'(evict_valid), 64'd0);
    check("refill4 evict_tag holds", 64'(evict_tag), 64'hA1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
